// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one 128-bit block memory port between the I-cache and D-cache
//
// Ports:
//    CLK, RESET                    clock, asynchronous active-low reset
//    i_read, i_address             instruction-cache block read request
//    i_readdata, i_busywait        instruction block returned, stall to I-cache
//    d_read, d_write, d_address    data-cache block read / write-back request
//    d_writedata                   write-back block
//    d_readdata, d_busywait        data block returned, stall to D-cache
//    m_read, m_write, m_address    registered request to backing memory
//    m_writedata                   registered write block to backing memory
//    m_readdata, m_busywait        backing memory read block and stall

module memory_port_arbiter (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          i_read,
   input  logic [27:0]   i_address,
   output logic [127:0]  i_readdata,
   output logic          i_busywait,
   input  logic          d_read,
   input  logic          d_write,
   input  logic [27:0]   d_address,
   input  logic [127:0]  d_writedata,
   output logic [127:0]  d_readdata,
   output logic          d_busywait,
   output logic          m_read,
   output logic          m_write,
   output logic [27:0]   m_address,
   output logic [127:0]  m_writedata,
   input  logic [127:0]  m_readdata,
   input  logic          m_busywait
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t         state_q,       state_d;
   logic           owner_q,       owner_d;
   logic           last_grant_q,  last_grant_d;
   logic           seen_busy_q,   seen_busy_d;
   logic           m_read_q,      m_read_d;
   logic           m_write_q,     m_write_d;
   logic [27:0]    m_address_q,   m_address_d;
   logic [127:0]   m_writedata_q, m_writedata_d;
   logic [127:0]   i_readdata_q,  i_readdata_d;
   logic [127:0]   d_readdata_q,  d_readdata_d;

   logic           i_req;
   logic           d_req;
   logic           win;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      seen_busy_d   = seen_busy_q;
      m_read_d      = m_read_q;
      m_write_d     = m_write_q;
      m_address_d   = m_address_q;
      m_writedata_d = m_writedata_q;
      i_readdata_d  = i_readdata_q;
      d_readdata_d  = d_readdata_q;
      win           = OWN_I;

      case (state_q)
         S_IDLE: begin
            if (i_req || d_req) begin
               // On a tie the requester that did not win last time goes first.
               if (i_req && d_req) begin
                  win = ~last_grant_q;
               end else begin
                  win = d_req;
               end
               owner_d      = win;
               last_grant_d = win;
               seen_busy_d  = 1'b0;
               state_d      = S_ISSUE;
               if (win == OWN_D) begin
                  m_address_d   = d_address;
                  m_writedata_d = d_writedata;
                  // A simultaneous read and write is treated as a write.
                  m_write_d     = d_write;
                  m_read_d      = ~d_write;
               end else begin
                  m_address_d = i_address;
                  m_read_d    = 1'b1;
                  m_write_d   = 1'b0;
               end
            end
         end

         S_ISSUE, S_WAIT: begin
            // Memory must be seen busy at least once before a low
            // busywait counts as completion; otherwise keep waiting.
            if (m_busywait) begin
               seen_busy_d = 1'b1;
               state_d     = S_WAIT;
            end else if (seen_busy_q) begin
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               if (m_read_q) begin
                  if (owner_q == OWN_D) begin
                     d_readdata_d = m_readdata;
                  end else begin
                     i_readdata_d = m_readdata;
                  end
               end
               state_d = S_RESPOND;
            end
         end

         S_RESPOND: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_I;
         last_grant_q  <= OWN_I;
         seen_busy_q   <= 1'b0;
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= '0;
         m_writedata_q <= '0;
         i_readdata_q  <= '0;
         d_readdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         seen_busy_q   <= seen_busy_d;
         m_read_q      <= m_read_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
         i_readdata_q  <= i_readdata_d;
         d_readdata_q  <= d_readdata_d;
      end
   end

   // Stalls follow the requests combinationally; only the owner's RESPOND
   // cycle releases a requester, so the loser stays stalled throughout.
   assign i_busywait = i_read & ~((state_q == S_RESPOND) && (owner_q == OWN_I));
   assign d_busywait = (d_read | d_write) & ~((state_q == S_RESPOND) && (owner_q == OWN_D));

   assign m_read      = m_read_q;
   assign m_write     = m_write_q;
   assign m_address   = m_address_q;
   assign m_writedata = m_writedata_q;
   assign i_readdata  = i_readdata_q;
   assign d_readdata  = d_readdata_q;

endmodule
